// File: rtl/flash_rd_arbiter.sv
// Shares one QSPI flash line-reader between the instruction-fetch (m0) and
// data-fetch (m1) cache front-ends, one burst at a time.
module flash_rd_arbiter #(
  parameter int AW      = 24,
  parameter int LW      = 4,
  parameter int PRIO_M0 = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [LW-1:0] m0_len,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic          m0_done,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [LW-1:0] m1_len,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic          m1_done,
  output logic [31:0]   rdata,
  output logic          fr_start,
  output logic [AW-1:0] fr_addr,
  output logic [LW-1:0] fr_len,
  input  logic          fr_busy,
  input  logic [31:0]   fr_rdata,
  input  logic          fr_rvalid,
  input  logic          fr_done,
  output logic          owner,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t      state, state_nxt;
  logic [LW:0] beat_cnt, beat_tgt, beat_end;
  logic        accept, pick_m1, beat_ok, beat_over, xfer_done;

  assign accept = (state == IDLE) && (m0_req || m1_req) && !fr_busy;

  // A contested round-robin slot goes to the port that did not own the last burst.
  assign pick_m1 = (PRIO_M0 != 0)        ? !m0_req :
                   (m0_req && m1_req)    ? !owner  : m1_req;

  assign beat_tgt  = {1'b0, fr_len} + {{LW{1'b0}}, 1'b1};
  assign beat_ok   = (state == XFER) && fr_rvalid && (beat_cnt != beat_tgt);
  assign beat_over = (state == XFER) && fr_rvalid && (beat_cnt == beat_tgt);
  assign xfer_done = (state == XFER) && fr_done;
  assign beat_end  = beat_cnt + {{LW{1'b0}}, beat_ok};
  assign rdata     = fr_rdata;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = START;
      START:   if (!fr_busy) state_nxt = XFER;
      XFER:    if (fr_done)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fr_start  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      START: fr_start = !fr_busy;
      XFER: begin
        m0_rvalid = beat_ok && !owner;
        m1_rvalid = beat_ok && owner;
        m0_done   = fr_done && !owner;
        m1_done   = fr_done && owner;
      end
      default: ;
    endcase
  end

  // Owner resets to m1 so that m0 wins the first contested round-robin slot.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner    <= 1'b1;
      fr_addr  <= '0;
      fr_len   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
    end else begin
      m0_gnt <= accept && !pick_m1;
      m1_gnt <= accept && pick_m1;
      if (accept) begin
        owner    <= pick_m1;
        fr_addr  <= pick_m1 ? m1_addr : m0_addr;
        fr_len   <= pick_m1 ? m1_len : m0_len;
        beat_cnt <= '0;
      end else if (beat_ok) begin
        beat_cnt <= beat_end;
      end
      if (beat_over || (xfer_done && (beat_end != beat_tgt)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// Bench for flash_rd_arbiter: a round-robin and an m0-priority instance share
// one stimulus stream; each is checked against a per-instance burst-level model.
module tb_flash_rd_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        m0_req, m1_req, fr_busy, fr_rvalid, fr_done;
  logic [23:0] m0_addr, m1_addr;
  logic [3:0]  m0_len, m1_len;
  logic [31:0] fr_rdata;

  logic [1:0]  gnt0, gnt1, rv0, rv1, dn0, dn1, frs, own, bsy, erv;
  logic [31:0] rdat [2];
  logic [23:0] fra  [2];
  logic [3:0]  frl  [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit mdl_owner [2];
  bit mdl_err   [2];
  bit use_fixed = 1'b0;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    flash_rd_arbiter #(.AW(24), .LW(4), .PRIO_M0(g)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len),
      .m0_gnt(gnt0[g]), .m0_rvalid(rv0[g]), .m0_done(dn0[g]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len),
      .m1_gnt(gnt1[g]), .m1_rvalid(rv1[g]), .m1_done(dn1[g]),
      .rdata(rdat[g]), .fr_start(frs[g]), .fr_addr(fra[g]), .fr_len(frl[g]),
      .fr_busy(fr_busy), .fr_rdata(fr_rdata), .fr_rvalid(fr_rvalid), .fr_done(fr_done),
      .owner(own[g]), .busy(bsy[g]), .err(erv[g])
    );
  end

  task automatic checkOutput(input string tag, input int d, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input logic [23:0] a0,
                               input logic [23:0] a1, input logic [3:0] l0,
                               input logic [3:0] l1, input bit fb, input bit rv,
                               input bit dn, input logic [31:0] dat);
    m0_req = r0; m1_req = r1; m0_addr = a0; m1_addr = a1; m0_len = l0; m1_len = l1;
    fr_busy = fb; fr_rvalid = rv; fr_done = dn; fr_rdata = dat;
  endtask

  // Instance 0 is round-robin, instance 1 gives m0 absolute priority.
  function automatic bit winner(input int d, input bit r0, input bit r1);
    if (d == 1) return !r0;
    if (r0 && r1) return !mdl_owner[0];
    return r1;
  endfunction

  function automatic logic [1:0] port_vec(input bit w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic checkReset(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput({tag, "_busy"}, d, bsy[d], 1'b0);
      checkOutput({tag, "_owner"}, d, own[d], 1'b1);
      checkOutput({tag, "_gnt"}, d, {gnt1[d], gnt0[d]}, 2'b00);
      checkOutput({tag, "_rvalid"}, d, {rv1[d], rv0[d]}, 2'b00);
      checkOutput({tag, "_done"}, d, {dn1[d], dn0[d]}, 2'b00);
      checkOutput({tag, "_frstart"}, d, frs[d], 1'b0);
      checkOutput({tag, "_fraddr"}, d, fra[d], 24'h0);
      checkOutput({tag, "_frlen"}, d, frl[d], 4'h0);
      checkOutput({tag, "_err"}, d, erv[d], 1'b0);
    end
  endtask

  task automatic doReset();
    @(negedge HCLK);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    HRESET = 1'b1;
    #1;
    checkReset("reset");
    mdl_owner = '{1'b1, 1'b1};
    mdl_err   = '{1'b0, 1'b0};
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic runBurst(input bit r0, input bit r1, input logic [23:0] a0,
                          input logic [23:0] a1, input logic [3:0] l0, input logic [3:0] l1,
                          input int idle_busy, input int start_busy, input int n_words,
                          input int abort_at);
    bit          w [2];
    logic [3:0]  wl [2];
    logic [23:0] wa [2];
    int          delivered, gaps;
    bit          last_with_done, dn;
    logic [31:0] dat;
    for (int d = 0; d < 2; d++) begin
      w[d]  = winner(d, r0, r1);
      wl[d] = w[d] ? l1 : l0;
      wa[d] = w[d] ? a1 : a0;
    end
    for (int k = 0; k <= idle_busy; k++) begin
      @(negedge HCLK);
      applyStimulus(r0, r1, a0, a1, l0, l1, k < idle_busy, 0, 0, 32'h0);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("idle_busy", d, bsy[d], 1'b0);
        checkOutput("idle_gnt", d, {gnt1[d], gnt0[d]}, 2'b00);
      end
    end
    for (int k = 0; k <= start_busy; k++) begin
      @(negedge HCLK);
      applyStimulus(0, 0, a0, a1, l0, l1, k < start_busy, 0, 0, 32'h0);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("start_gnt", d, {gnt1[d], gnt0[d]}, (k == 0) ? port_vec(w[d]) : 2'b00);
        checkOutput("start_busy", d, bsy[d], 1'b1);
        checkOutput("start_owner", d, own[d], w[d]);
        checkOutput("start_fraddr", d, fra[d], wa[d]);
        checkOutput("start_frlen", d, frl[d], wl[d]);
        checkOutput("start_frstart", d, frs[d], k == start_busy);
      end
    end
    delivered      = 0;
    gaps           = 0;
    last_with_done = bit'($urandom_range(0, 1));
    while (delivered < n_words) begin
      @(negedge HCLK);
      if (gaps < 2 && $urandom_range(0, 3) == 0) begin
        gaps++;
        applyStimulus(0, 0, a0, a1, l0, l1, 1, 0, 0, $urandom);
        #1;
        for (int d = 0; d < 2; d++) begin
          checkOutput("gap_rvalid", d, {rv1[d], rv0[d]}, 2'b00);
          checkOutput("gap_done", d, {dn1[d], dn0[d]}, 2'b00);
        end
        continue;
      end
      gaps = 0;
      dat  = use_fixed ? (delivered + 1) * 32'h11111111 : $urandom;
      dn   = last_with_done && (delivered == n_words - 1);
      if (abort_at == delivered) begin
        applyStimulus(0, 0, a0, a1, l0, l1, 1, 1, 1, dat);
        HRESET = 1'b1;
        #1;
        checkReset("abort");
        mdl_owner = '{1'b1, 1'b1};
        mdl_err   = '{1'b0, 1'b0};
        @(negedge HCLK);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        HRESET = 1'b0;
        return;
      end
      applyStimulus(0, 0, a0, a1, l0, l1, 1, 1, dn, dat);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("beat_rvalid", d, {rv1[d], rv0[d]},
                    (delivered < wl[d] + 1) ? port_vec(w[d]) : 2'b00);
        checkOutput("beat_rdata", d, rdat[d], dat);
        checkOutput("beat_done", d, {dn1[d], dn0[d]}, dn ? port_vec(w[d]) : 2'b00);
      end
      delivered++;
    end
    if (!last_with_done) begin
      @(negedge HCLK);
      applyStimulus(0, 0, a0, a1, l0, l1, 1, 0, 1, 32'h0);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("done_pulse", d, {dn1[d], dn0[d]}, port_vec(w[d]));
        checkOutput("done_rvalid", d, {rv1[d], rv0[d]}, 2'b00);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (n_words != wl[d] + 1) mdl_err[d] = 1'b1;
      mdl_owner[d] = w[d];
    end
    @(negedge HCLK);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("post_busy", d, bsy[d], 1'b0);
      checkOutput("post_err", d, erv[d], mdl_err[d]);
      checkOutput("post_owner", d, own[d], mdl_owner[d]);
      checkOutput("post_done", d, {dn1[d], dn0[d]}, 2'b00);
    end
  endtask

  initial begin
    bit          r0, r1;
    logic [3:0]  l0, l1, lw;
    HRESET = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    mdl_owner = '{1'b1, 1'b1};
    mdl_err   = '{1'b0, 1'b0};
    repeat (2) @(negedge HCLK);
    #1;
    checkReset("init");
    @(negedge HCLK);
    HRESET = 1'b0;

    $display("[TB] single m0 burst, len=3");
    use_fixed = 1'b1;
    runBurst(1, 0, 24'h000000, 24'h0, 4'd3, 4'd0, 0, 0, 4, -1);
    use_fixed = 1'b0;

    $display("[TB] contention after reset");
    doReset();
    repeat (3) runBurst(1, 1, 24'h000100, 24'h000200, 4'd0, 4'd0, 0, 0, 1, -1);
    runBurst(0, 1, 24'h000100, 24'h000200, 4'd0, 4'd0, 0, 0, 1, -1);

    $display("[TB] reader busy in IDLE and START");
    runBurst(1, 0, 24'h00abcd, 24'h0, 4'd2, 4'd0, 2, 5, 3, -1);

    $display("[TB] randomized bursts, exact length");
    for (int i = 0; i < 12; i++) begin
      r0 = bit'($urandom_range(0, 1));
      r1 = r0 ? bit'($urandom_range(0, 1)) : 1'b1;
      l0 = 4'($urandom_range(0, 15));
      l1 = 4'($urandom_range(0, 15));
      lw = winner(0, r0, r1) ? l1 : l0;
      runBurst(r0, r1, 24'($urandom), 24'($urandom), l0, l1, $urandom_range(0, 1),
               $urandom_range(0, 2), lw + 1, -1);
    end

    $display("[TB] overflow word then normal burst");
    runBurst(1, 0, 24'h000040, 24'h0, 4'd1, 4'd1, 0, 0, 3, -1);
    runBurst(0, 1, 24'h0, 24'h000080, 4'd1, 4'd1, 0, 0, 2, -1);

    $display("[TB] reset mid-transfer");
    runBurst(1, 0, 24'h001000, 24'h0, 4'd3, 4'd0, 0, 0, 4, 2);
    runBurst(0, 1, 24'h0, 24'h002000, 4'd0, 4'd5, 0, 0, 6, -1);

    $display("[TB] randomized bursts, length errors included");
    for (int i = 0; i < 8; i++) begin
      r0 = bit'($urandom_range(0, 1));
      r1 = r0 ? bit'($urandom_range(0, 1)) : 1'b1;
      l0 = 4'($urandom_range(0, 15));
      l1 = 4'($urandom_range(0, 15));
      runBurst(r0, r1, 24'($urandom), 24'($urandom), l0, l1, 0,
               $urandom_range(0, 1), $urandom_range(1, 16), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_rd_arbiter.md
Name: flash_rd_arbiter

Overview:
- Shares one QSPI flash line-reader between two requesters: port m0 (instruction-fetch cache line fill) and port m1 (data/literal fetch).
- Accepts one burst request at a time, issues it to the reader, steers returned words to the owning port and signals completion.
- Sits between the AHB-Lite flash cache front-ends and the flash reader FSM that drives csn/sck/doe/do.

Parameters:
AW, 24, flash byte-address width
LW, 4, burst-length field width; len = words-1, so 1..2^LW words per burst
PRIO_M0, 0, 0 = round-robin arbitration; 1 = m0 always wins

Ports:
HCLK  in  1  clock, all state on rising edge
HRESET  in  1  asynchronous reset, active-high
m0_req  in  1  m0 burst request, held with m0_addr/m0_len until m0_gnt
m0_addr  in  AW  m0 start byte address
m0_len  in  LW  m0 words-1
m0_gnt  out  1  one-cycle pulse: m0 request accepted
m0_rvalid  out  1  rdata holds a word for m0
m0_done  out  1  one-cycle pulse: m0 burst complete
m1_req, m1_addr, m1_len, m1_gnt, m1_rvalid, m1_done  as m0, for m1
rdata  out  32  returned word, shared by both ports
fr_start  out  1  one-cycle pulse: start a reader burst
fr_addr  out  AW  registered burst address
fr_len  out  LW  registered burst words-1
fr_busy  in  1  reader is busy
fr_rdata  in  32  reader data word
fr_rvalid  in  1  fr_rdata valid
fr_done  in  1  reader burst finished (pulse)
owner  out  1  current/last owner (0 = m0, 1 = m1)
busy  out  1  state != IDLE
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, HRESET=1): state IDLE; owner=1 (m0 wins first round-robin contest); fr_addr=0, fr_len=0, beat counter=0, err=0; all gnt/rvalid/done/fr_start outputs 0; rdata=fr_rdata pass-through, value don't-care.
- Reset mid-burst aborts immediately, no done pulse. The reader is reset by the same HRESET.
- States: IDLE, START, XFER.
- IDLE:
  - If any req is high at an edge: select winner, latch its addr/len into fr_addr/fr_len, set owner, clear beat counter, go START.
  - Winner's gnt is registered and is high for exactly the first START cycle.
  - Requests are not accepted while fr_busy=1.
- Arbitration:
  - PRIO_M0=1: m0 whenever m0_req.
  - PRIO_M0=0: single request wins; on contention the winner is !owner.
- START: fr_start = (state==START && !fr_busy), combinational. On the edge where fr_start=1, go XFER. Otherwise stay in START; gnt is not repeated.
- XFER:
  - mX_rvalid = fr_rvalid && owner==X, combinational; rdata = fr_rdata.
  - Each fr_rvalid increments the beat counter (width LW+1).
  - fr_rvalid when counter already equals len+1: word is dropped (no rvalid) and err is set.
  - fr_done: mX_done = fr_done && owner==X, combinational, same cycle; go IDLE. If counter+fr_rvalid != len+1 at done, set err.
  - fr_rvalid and fr_done in the same cycle is legal; that word counts.
- Throughput: minimum 1 IDLE cycle between bursts. Earliest next gnt is visible 2 cycles after done.
- A requester keeping req high after done is treated as a new request.
- A req dropped before gnt is a protocol violation, not checked. The request is latched at the IDLE edge.
- err clears only on reset.

Test Plan:
- Single m0 request, addr=0x000000, len=3, fr_busy=0, reader model returns 0x11111111..0x44444444 → m0_gnt 1 cycle after req edge; fr_start next cycle with fr_addr=0x000000, fr_len=3; 4 m0_rvalid beats with matching rdata; m0_done with fr_done; m1 outputs stay 0; err=0.
- m0 and m1 request at the same edge (m0 addr 0x100, m1 addr 0x200, len 0), PRIO_M0=0, after reset → m0 served first, then m1 (fr_addr=0x200). Both held high again → grants alternate m0, m1, m0.
- Same contention with PRIO_M0=1 and m0_req held high for 3 bursts → m1 never granted while m0_req=1; m1 granted after m0_req drops.
- fr_busy held high for 5 cycles after gnt → state stays START, fr_start is 0 for those 5 cycles and then pulses exactly once.
- Reader returns 3 words for len=1 → third word has no rvalid and err=1. Next burst is served normally and err stays 1.
- HRESET asserted mid-XFER after 2 of 4 beats → busy, rvalid, done and gnt all 0 asynchronously; owner=1; after release a new m1 request completes normally.
